// File: rtl/pwm_update_sequencer_pkg.sv
// Shared types and constants for the PWM configuration/update sequencer.
package pwm_update_sequencer_pkg;

  localparam int unsigned CFG_W    = 16;
  localparam int unsigned CLKDIV_W = 5;
  localparam int unsigned DTIME_W  = 8;
  localparam int unsigned ADDR_W   = 3;

  // Shadow write address map
  localparam logic [ADDR_W-1:0] ADDR_PERIOD    = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_INIT_CARR = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_COMPARE   = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_CLKDIV    = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_DTIME     = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_MODES     = 3'd5;

  // Bit positions inside the modes word
  localparam int unsigned MODE_CNT_LSB  = 0;
  localparam int unsigned MODE_CNT_MSB  = 1;
  localparam int unsigned MODE_MASK_LSB = 2;
  localparam int unsigned MODE_MASK_MSB = 3;

  typedef enum logic [1:0] {
    COUNT_UP     = 2'd0,
    COUNT_DOWN   = 2'd1,
    COUNT_UPDOWN = 2'd2,
    COUNT_RSVD   = 2'd3
  } _count_mode;

  typedef enum logic [1:0] {
    NO_MASK     = 2'd0,
    MIN_MASK    = 2'd1,
    MAX_MASK    = 2'd2,
    MINMAX_MASK = 2'd3
  } _mask_mode;

  typedef enum logic [1:0] {
    PWM_OFF = 2'd0,
    PWM_ON  = 2'd1
  } _pwm_onoff;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RAMP     = 3'd1,
    RUN      = 3'd2,
    ARMED    = 3'd3,
    STOPPING = 3'd4
  } _seq_state;

  // One complete PWM configuration set (shadow or active)
  typedef struct packed {
    logic [CFG_W-1:0]    period;
    logic [CFG_W-1:0]    init_carr;
    logic [CFG_W-1:0]    compare;
    logic [CLKDIV_W-1:0] clk_divider;
    logic [DTIME_W-1:0]  dtime;
    _count_mode          count_mode;
    _mask_mode           mask_mode;
  } pwm_cfg_t;

  function automatic logic [CFG_W-1:0] min16(input logic [CFG_W-1:0] a,
                                             input logic [CFG_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/pwm_valley_detect.sv
// Carrier valley detector: flags the cycle where the carrier falls to zero.
module pwm_valley_detect
  import pwm_update_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [CFG_W-1:0] carrier_i,
  output logic             vev_c
);

  logic [CFG_W-1:0] carrier_q;

  // Previous-cycle carrier; a stalled carrier holds its value so no false edge
  always_ff @(posedge clk) begin
    if (reset) carrier_q <= '0;
    else       carrier_q <= carrier_i;
  end

  assign vev_c = (carrier_i == '0) && (carrier_q != '0);

endmodule

// File: rtl/pwm_update_sequencer.sv
// Shadow/active configuration sequencer for one pwm_16bits instance.
module pwm_update_sequencer
  import pwm_update_sequencer_pkg::*;
#(
  parameter int unsigned RAMP_STEP  = 16,
  parameter int unsigned RST_PERIOD = 2000,
  parameter int unsigned RST_DTIME  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [CFG_W-1:0]    wr_data,
  input  logic                start,
  input  logic                stop,
  input  logic                commit,
  input  logic [CFG_W-1:0]    carrier,
  output logic [CFG_W-1:0]    period,
  output logic [CFG_W-1:0]    init_carr,
  output logic [CFG_W-1:0]    compare,
  output logic [CLKDIV_W-1:0] clk_divider,
  output logic [DTIME_W-1:0]  dtime,
  output _count_mode          count_mode,
  output _mask_mode           mask_mode,
  output _pwm_onoff           pwm_onoff,
  output logic                busy,
  output logic [2:0]          state_o
);

  localparam pwm_cfg_t RST_CFG = '{
    period:      CFG_W'(RST_PERIOD),
    init_carr:   '0,
    compare:     '0,
    clk_divider: '0,
    dtime:       DTIME_W'(RST_DTIME),
    count_mode:  COUNT_UPDOWN,
    mask_mode:   MAX_MASK
  };

  pwm_cfg_t   shadow_q, shadow_d;
  pwm_cfg_t   active_q, active_d;
  pwm_cfg_t   load_cfg;
  _pwm_onoff  onoff_q, onoff_d;
  _seq_state  state_q, state_d;
  logic       wr_ready_q, wr_ready_d;
  logic       busy_q, busy_d;
  logic       vev_c;
  logic [CFG_W-1:0] ramp_tgt;
  logic [CFG_W:0]   ramp_sum;
  logic [CFG_W-1:0] ramp_next;

  pwm_valley_detect u_valley (
    .clk       (clk),
    .reset     (reset),
    .carrier_i (carrier),
    .vev_c     (vev_c)
  );

  // Next-state: shadow writes, atomic loads and start/ramp/stop sequencing
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    onoff_d  = onoff_q;
    state_d  = state_q;

    // Whole shadow set, compare already clamped to the period it travels with
    load_cfg         = shadow_q;
    load_cfg.compare = min16(shadow_q.compare, shadow_q.period);

    // Ramp target never exceeds the period the PWM is running with
    ramp_tgt  = min16(shadow_q.compare, active_q.period);
    ramp_sum  = {1'b0, active_q.compare} + (CFG_W+1)'(RAMP_STEP);
    ramp_next = (ramp_sum >= {1'b0, ramp_tgt}) ? ramp_tgt : ramp_sum[CFG_W-1:0];

    if (wr_valid && wr_ready_q) begin
      case (wr_addr)
        ADDR_PERIOD:    shadow_d.period      = wr_data;
        ADDR_INIT_CARR: shadow_d.init_carr   = wr_data;
        ADDR_COMPARE:   shadow_d.compare     = wr_data;
        ADDR_CLKDIV:    shadow_d.clk_divider = wr_data[CLKDIV_W-1:0];
        ADDR_DTIME:     shadow_d.dtime       = wr_data[DTIME_W-1:0];
        ADDR_MODES: begin
          shadow_d.count_mode = _count_mode'(wr_data[MODE_CNT_MSB:MODE_CNT_LSB]);
          shadow_d.mask_mode  = _mask_mode'(wr_data[MODE_MASK_MSB:MODE_MASK_LSB]);
        end
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (commit) begin
          active_d = load_cfg;
        end else if (start) begin
          active_d         = shadow_q;
          active_d.compare = '0;
          onoff_d          = PWM_ON;
          state_d          = RAMP;
        end
      end
      RAMP: begin
        if (stop) begin
          state_d = STOPPING;
        end else if (vev_c) begin
          active_d.compare = ramp_next;
          if (ramp_next == ramp_tgt) state_d = RUN;
        end
      end
      RUN: begin
        if (stop)        state_d = STOPPING;
        else if (commit) state_d = ARMED;
      end
      ARMED: begin
        if (stop) begin
          state_d = STOPPING;
        end else if (vev_c) begin
          active_d = load_cfg;
          state_d  = RUN;
        end
      end
      STOPPING: begin
        if (vev_c) begin
          onoff_d          = PWM_OFF;
          active_d.compare = '0;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ready_d = (state_d != ARMED);
    busy_d     = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q   <= RST_CFG;
      active_q   <= RST_CFG;
      onoff_q    <= PWM_OFF;
      state_q    <= IDLE;
      wr_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      onoff_q    <= onoff_d;
      state_q    <= state_d;
      wr_ready_q <= wr_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign period      = active_q.period;
  assign init_carr   = active_q.init_carr;
  assign compare     = active_q.compare;
  assign clk_divider = active_q.clk_divider;
  assign dtime       = active_q.dtime;
  assign count_mode  = active_q.count_mode;
  assign mask_mode   = active_q.mask_mode;
  assign pwm_onoff   = onoff_q;
  assign wr_ready    = wr_ready_q;
  assign busy        = busy_q;
  assign state_o     = 3'(state_q);

endmodule

// File: tb/tb_pwm_update_sequencer.sv
// Randomized scoreboard bench for pwm_update_sequencer.
module tb_pwm_update_sequencer;
  import pwm_update_sequencer_pkg::*;

  localparam int STEP = 16;
  localparam int CMAX = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  wr_addr = 3'd0;
  logic [15:0] wr_data = 16'd0;
  logic        start = 1'b0, stop = 1'b0, commit = 1'b0;
  logic [15:0] carrier = 16'd0;
  logic [15:0] period, init_carr, compare;
  logic [4:0]  clk_divider;
  logic [7:0]  dtime;
  _count_mode  count_mode;
  _mask_mode   mask_mode;
  _pwm_onoff   pwm_onoff;
  logic        busy;
  logic [2:0]  state_o;

  pwm_update_sequencer #(.RAMP_STEP(STEP), .RST_PERIOD(2000), .RST_DTIME(10)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .stop(stop),
    .commit(commit), .carrier(carrier), .period(period), .init_carr(init_carr),
    .compare(compare), .clk_divider(clk_divider), .dtime(dtime),
    .count_mode(count_mode), .mask_mode(mask_mode), .pwm_onoff(pwm_onoff),
    .busy(busy), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct { int period, init_carr, compare, clkdiv, dtime, cmode, mmode; } cfg_t;
  typedef struct { cfg_t c; int onoff, busy, st, rdy; } exp_t;

  exp_t exp_q[$];
  cfg_t sh, act;
  int   m_on, m_st, m_rdy, m_prev_car;
  bit   m_vev, m_acc;
  int   checks = 0, errors = 0;

  // Next-cycle stimulus, applied at the following falling edge
  bit n_reset = 1'b1, n_wv = 1'b0, n_start = 1'b0, n_stop = 1'b0, n_commit = 1'b0;
  int n_wa = 0, n_wd = 0;
  int car_idx = 0, car_dir = 1;

  function automatic cfg_t rst_cfg();
    cfg_t c;
    c.period = 2000; c.init_carr = 0; c.compare = 0; c.clkdiv = 0; c.dtime = 10;
    c.cmode = int'(COUNT_UPDOWN); c.mmode = int'(MAX_MASK);
    return c;
  endfunction

  function automatic cfg_t loaded(cfg_t s);
    cfg_t c = s;
    if (c.compare > c.period) c.compare = c.period;
    return c;
  endfunction

  function automatic void check(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endfunction

  // Reference model: one clock of the sequencer rules, result queued for the monitor
  task automatic model_step();
    cfg_t nsh;
    int   tgt, nc;
    exp_t e;
    if (reset) begin
      sh = rst_cfg(); act = rst_cfg();
      m_on = 0; m_st = 0; m_rdy = 1; m_prev_car = 0; m_vev = 0; m_acc = 0;
    end else begin
      m_vev = (carrier == 16'd0) && (m_prev_car != 0);
      m_prev_car = int'(carrier);
      m_acc = wr_valid && (m_rdy == 1);
      nsh = sh;
      if (m_acc) begin
        case (int'(wr_addr))
          0: nsh.period    = int'(wr_data);
          1: nsh.init_carr = int'(wr_data);
          2: nsh.compare   = int'(wr_data);
          3: nsh.clkdiv    = int'(wr_data) % 32;
          4: nsh.dtime     = int'(wr_data) % 256;
          5: begin nsh.cmode = int'(wr_data) % 4; nsh.mmode = (int'(wr_data) / 4) % 4; end
          default: ;
        endcase
      end
      case (m_st)
        0: if (commit) act = loaded(sh);
           else if (start) begin act = sh; act.compare = 0; m_on = 1; m_st = 1; end
        1: if (stop) m_st = 4;
           else if (m_vev) begin
             tgt = (sh.compare < act.period) ? sh.compare : act.period;
             nc = act.compare + STEP;
             if (nc > tgt) nc = tgt;
             act.compare = nc;
             if (nc == tgt) m_st = 2;
           end
        2: if (stop) m_st = 4; else if (commit) m_st = 3;
        3: if (stop) m_st = 4;
           else if (m_vev) begin act = loaded(sh); m_st = 2; end
        default: if (m_vev) begin m_on = 0; act.compare = 0; m_st = 0; end
      endcase
      sh = nsh;
      m_rdy = (m_st != 3) ? 1 : 0;
    end
    e.c = act; e.onoff = m_on; e.busy = (m_st != 0) ? 1 : 0; e.st = m_st; e.rdy = m_rdy;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus at the falling edge and advance the model
  task automatic cyc();
    @(negedge clk);
    reset = n_reset; wr_valid = n_wv; wr_addr = 3'(n_wa); wr_data = 16'(n_wd);
    start = n_start; stop = n_stop; commit = n_commit;
    if ($urandom_range(3) != 0) begin
      car_idx += car_dir;
      if (car_idx >= CMAX) car_dir = -1;
      else if (car_idx <= 0) car_dir = 1;
    end
    carrier = 16'(car_idx * 300);
    model_step();
    n_start = 0; n_stop = 0; n_commit = 0;
    if (m_acc) n_wv = 0;
  endtask

  task automatic do_write(int a, int d);
    n_wv = 1; n_wa = a; n_wd = d;
    for (int i = 0; i < 400; i++) begin
      cyc();
      if (m_acc) return;
    end
    check("write_accept_timeout", 0, 1);
    n_wv = 0;
  endtask

  task automatic wait_state(int s, string name);
    for (int i = 0; i < 6000; i++) begin
      if (int'(state_o) == s) return;
      cyc();
    end
    check(name, int'(state_o), s);
  endtask

  // Monitor: every cycle the DUT presents a full output set, compared to the queue head
  exp_t got_e;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      got_e = exp_q.pop_front();
      checks++;
      if (int'(period) != got_e.c.period || int'(init_carr) != got_e.c.init_carr ||
          int'(compare) != got_e.c.compare || int'(clk_divider) != got_e.c.clkdiv ||
          int'(dtime) != got_e.c.dtime || int'(count_mode) != got_e.c.cmode ||
          int'(mask_mode) != got_e.c.mmode || int'(pwm_onoff) != got_e.onoff ||
          int'(busy) != got_e.busy || int'(state_o) != got_e.st || int'(wr_ready) != got_e.rdy) begin
        errors++;
        $display("FAIL outputs t=%0t got per=%0d ic=%0d cmp=%0d div=%0d dt=%0d cm=%0d mm=%0d on=%0d busy=%0d st=%0d rdy=%0d expected per=%0d ic=%0d cmp=%0d div=%0d dt=%0d cm=%0d mm=%0d on=%0d busy=%0d st=%0d rdy=%0d",
                 $time, period, init_carr, compare, clk_divider, dtime, count_mode, mask_mode,
                 pwm_onoff, busy, state_o, wr_ready, got_e.c.period, got_e.c.init_carr,
                 got_e.c.compare, got_e.c.clkdiv, got_e.c.dtime, got_e.c.cmode, got_e.c.mmode,
                 got_e.onoff, got_e.busy, got_e.st, got_e.rdy);
      end
    end
  end

  int cnt, guard;

  initial begin
    // Reset defaults
    repeat (3) cyc();
    n_reset = 0;
    cyc();
    check("rst_period", int'(period), 2000);
    check("rst_dtime", int'(dtime), 10);
    check("rst_compare", int'(compare), 0);
    check("rst_onoff", int'(pwm_onoff), int'(PWM_OFF));
    check("rst_wr_ready", int'(wr_ready), 1);
    check("rst_busy", int'(busy), 0);

    // Soft start ramp to 1000 in steps of 16
    do_write(0, 2000);
    do_write(2, 1000);
    n_start = 1;
    cyc();
    cnt = 0;
    for (guard = 0; guard < 5000; guard++) begin
      cyc();
      if (int'(state_o) == 2) break;
      if (m_vev) cnt++;
    end
    check("ramp_valleys_to_run", cnt, 63);
    check("ramp_final_compare", int'(compare), 1000);

    // Commit mid-period: compare held until valley, writes stalled while armed
    while (car_idx < 3) cyc();
    do_write(2, 667);
    n_commit = 1;
    cyc();
    cyc();
    check("armed_state", int'(state_o), 3);
    check("armed_wr_ready", int'(wr_ready), 0);
    check("armed_compare_held", int'(compare), 1000);
    do_write(0, 1500);
    check("write_after_update_compare", int'(compare), 667);
    check("write_after_update_state", int'(state_o), 2);

    // Smaller period with larger compare: clamp at the valley
    do_write(2, 1800);
    n_commit = 1;
    cyc();
    cyc();
    wait_state(2, "armed_to_run_timeout");
    check("clamp_period", int'(period), 1500);
    check("clamp_compare", int'(compare), 1500);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      n_reset = ($urandom_range(999) < 3);
      if ($urandom_range(99) < 10) n_start = 1;
      if ($urandom_range(99) < 4)  n_stop = 1;
      if ($urandom_range(99) < 8)  n_commit = 1;
      if (!n_wv && $urandom_range(99) < 15) begin
        n_wv = 1;
        n_wa = $urandom_range(7);
        n_wd = (n_wa == 0 || n_wa == 2) ? $urandom_range(3999) : $urandom_range(65535);
      end
      cyc();
    end
    n_reset = 1; n_wv = 0;
    cyc();
    n_reset = 0;

    // stop and commit together in RUN
    do_write(0, 2000);
    do_write(2, 48);
    n_start = 1;
    cyc();
    wait_state(2, "short_ramp_timeout");
    do_write(0, 1200);
    n_stop = 1; n_commit = 1;
    cyc();
    cyc();
    check("stop_commit_state", int'(state_o), 4);
    wait_state(0, "stopping_timeout");
    check("stop_onoff", int'(pwm_onoff), int'(PWM_OFF));
    check("stop_compare", int'(compare), 0);
    check("stop_period_kept", int'(period), 2000);

    // Reset while armed with a pending init_carr
    n_start = 1;
    cyc();
    wait_state(2, "restart_ramp_timeout");
    do_write(1, 600);
    while (car_idx < 3) cyc();
    n_commit = 1;
    cyc();
    cyc();
    check("armed_before_reset", int'(state_o), 3);
    n_reset = 1;
    cyc();
    n_reset = 0;
    cyc();
    check("rst_armed_state", int'(state_o), 0);
    check("rst_armed_onoff", int'(pwm_onoff), int'(PWM_OFF));
    check("rst_armed_period", int'(period), 2000);
    check("rst_armed_ready", int'(wr_ready), 1);
    n_commit = 1;
    cyc();
    cyc();
    check("rst_shadow_init_carr", int'(init_carr), 0);
    check("rst_shadow_period", int'(period), 2000);

    repeat (3) cyc();
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
